// File: rtl/nco_sweep_ctrl.sv
// nco_sweep_ctrl
//   Steps the phase increment of the NCO tone generator to make stepped frequency sweeps.
//   One configuration is taken over a valid/ready handshake. The block then drives phi_inc_o
//   through the sweep on its own. Three sweep shapes are supported: single up, repeating up,
//   and triangle (up/down).
//
// Ports
//   clk            system clock; all logic runs on the rising edge
//   reset_n        asynchronous active-low reset
//   cfg_valid      a configuration is present on the cfg_* inputs
//   cfg_ready      the block can take a configuration (high only when idle)
//   cfg_start_inc  first phase increment of the sweep
//   cfg_stop_inc   last (upper) phase increment
//   cfg_step       amount added or subtracted on each step
//   cfg_dwell      cycles each value is held; 0 is treated as 1
//   cfg_mode       00 single up, 01 repeat up, 10 triangle, 11 behaves as single
//   abort          stops a running sweep; phi_inc_o keeps its value
//   phi_inc_o      phase increment to the NCO
//   sweep_busy     a sweep is in progress
//   step_strobe    1-cycle pulse in the first cycle of each new phi_inc_o value
//   sweep_done     1-cycle pulse when a single sweep completes
module nco_sweep_ctrl #(
    parameter int unsigned PHASE_WIDTH = 16,
    parameter int unsigned DWELL_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   cfg_valid,
    output logic                   cfg_ready,
    input  logic [PHASE_WIDTH-1:0] cfg_start_inc,
    input  logic [PHASE_WIDTH-1:0] cfg_stop_inc,
    input  logic [PHASE_WIDTH-1:0] cfg_step,
    input  logic [DWELL_WIDTH-1:0] cfg_dwell,
    input  logic [1:0]             cfg_mode,
    input  logic                   abort,
    output logic [PHASE_WIDTH-1:0] phi_inc_o,
    output logic                   sweep_busy,
    output logic                   step_strobe,
    output logic                   sweep_done
);

    localparam int unsigned PW = PHASE_WIDTH;
    localparam int unsigned DW = DWELL_WIDTH;

    typedef enum logic [1:0] {StIdle, StUp, StDown} state_e;

    state_e          state_q, state_d;
    logic [PW-1:0]   phi_q, phi_d;
    logic [PW-1:0]   start_q, start_d;
    logic [PW-1:0]   stop_q, stop_d;
    logic [PW-1:0]   step_q, step_d;
    logic [DW-1:0]   dwell_q, dwell_d;    // effective dwell, always >= 1 once loaded
    logic [DW-1:0]   cnt_q, cnt_d;        // cycles left on the current value, minus one
    logic [1:0]      mode_q, mode_d;
    logic            degen_q, degen_d;
    logic            strobe_q, strobe_d;
    logic            done_q, done_d;

    logic [DW-1:0]   cfg_dwell_eff;
    logic [PW:0]     up_sum;
    logic [PW-1:0]   up_next;
    logic [PW-1:0]   dn_next;
    logic            expired;

    assign cfg_dwell_eff = (cfg_dwell == '0) ? DW'(1) : cfg_dwell;
    assign expired       = (cnt_q == '0);

    // Upward step done one bit wider so a carry-out clamps to stop instead of wrapping.
    assign up_sum  = {1'b0, phi_q} + {1'b0, step_q};
    assign up_next = (up_sum >= {1'b0, stop_q}) ? stop_q : up_sum[PW-1:0];

    // Downward step. phi_q >= start_q holds whenever this is used, so the difference
    // cannot borrow.
    assign dn_next = ((phi_q - start_q) <= step_q) ? start_q : (phi_q - step_q);

    always_comb begin
        state_d  = state_q;
        phi_d    = phi_q;
        start_d  = start_q;
        stop_d   = stop_q;
        step_d   = step_q;
        dwell_d  = dwell_q;
        cnt_d    = cnt_q;
        mode_d   = mode_q;
        degen_d  = degen_q;
        strobe_d = 1'b0;
        done_d   = 1'b0;

        unique case (state_q)
            StIdle: begin
                // abort is ignored here, so a handshake in the same cycle always wins.
                if (cfg_valid) begin
                    start_d  = cfg_start_inc;
                    stop_d   = cfg_stop_inc;
                    step_d   = cfg_step;
                    dwell_d  = cfg_dwell_eff;
                    mode_d   = cfg_mode;
                    degen_d  = (cfg_step == '0) || (cfg_start_inc >= cfg_stop_inc);
                    phi_d    = cfg_start_inc;
                    cnt_d    = cfg_dwell_eff - DW'(1);
                    strobe_d = 1'b1;
                    state_d  = StUp;
                end
            end

            StUp: begin
                if (abort) begin
                    state_d = StIdle;
                end else if (expired) begin
                    if (degen_q) begin
                        state_d = StIdle;
                        done_d  = 1'b1;
                    end else if (phi_q < stop_q) begin
                        phi_d    = up_next;
                        cnt_d    = dwell_q - DW'(1);
                        strobe_d = 1'b1;
                    end else begin
                        // At the top of the sweep.
                        unique case (mode_q)
                            2'b01: begin
                                phi_d    = start_q;
                                cnt_d    = dwell_q - DW'(1);
                                strobe_d = 1'b1;
                            end
                            2'b10: begin
                                phi_d    = dn_next;
                                cnt_d    = dwell_q - DW'(1);
                                strobe_d = 1'b1;
                                state_d  = StDown;
                            end
                            default: begin
                                state_d = StIdle;
                                done_d  = 1'b1;
                            end
                        endcase
                    end
                end
            end

            StDown: begin
                if (abort) begin
                    state_d = StIdle;
                end else if (expired) begin
                    cnt_d    = dwell_q - DW'(1);
                    strobe_d = 1'b1;
                    if (phi_q == start_q) begin
                        // phi_q == start_q here, so up_next is min(start+step, stop).
                        phi_d   = up_next;
                        state_d = StUp;
                    end else begin
                        phi_d = dn_next;
                    end
                end
            end

            default: state_d = StIdle;
        endcase

        // Count down while a value is held; the reload above takes precedence.
        if (state_q != StIdle && !abort && !expired) begin
            cnt_d = cnt_q - DW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= StIdle;
            phi_q    <= '0;
            start_q  <= '0;
            stop_q   <= '0;
            step_q   <= '0;
            dwell_q  <= '0;
            cnt_q    <= '0;
            mode_q   <= '0;
            degen_q  <= 1'b0;
            strobe_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            phi_q    <= phi_d;
            start_q  <= start_d;
            stop_q   <= stop_d;
            step_q   <= step_d;
            dwell_q  <= dwell_d;
            cnt_q    <= cnt_d;
            mode_q   <= mode_d;
            degen_q  <= degen_d;
            strobe_q <= strobe_d;
            done_q   <= done_d;
        end
    end

    assign phi_inc_o   = phi_q;
    assign step_strobe = strobe_q;
    assign sweep_done  = done_q;
    assign sweep_busy  = (state_q != StIdle);
    assign cfg_ready   = (state_q == StIdle);

endmodule

// File: tb/tb_nco_sweep_ctrl.sv
// Directed bench for nco_sweep_ctrl. Inputs change and outputs are sampled 1 time unit
// after each rising edge.
module tb_nco_sweep_ctrl;

    logic        clk;
    logic        reset_n;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [15:0] cfg_start_inc;
    logic [15:0] cfg_stop_inc;
    logic [15:0] cfg_step;
    logic [15:0] cfg_dwell;
    logic [1:0]  cfg_mode;
    logic        abort;
    logic [15:0] phi_inc_o;
    logic        sweep_busy;
    logic        step_strobe;
    logic        sweep_done;

    int n_vec;
    int n_miss;

    nco_sweep_ctrl #(
        .PHASE_WIDTH (16),
        .DWELL_WIDTH (16)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .cfg_valid     (cfg_valid),
        .cfg_ready     (cfg_ready),
        .cfg_start_inc (cfg_start_inc),
        .cfg_stop_inc  (cfg_stop_inc),
        .cfg_step      (cfg_step),
        .cfg_dwell     (cfg_dwell),
        .cfg_mode      (cfg_mode),
        .abort         (abort),
        .phi_inc_o     (phi_inc_o),
        .sweep_busy    (sweep_busy),
        .step_strobe   (step_strobe),
        .sweep_done    (sweep_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a configuration for one edge; returns in the first cycle of the start value.
    task automatic accept(input logic [15:0] s, input logic [15:0] p, input logic [15:0] st,
                          input logic [15:0] dw, input logic [1:0] m);
        cfg_start_inc = s;
        cfg_stop_inc  = p;
        cfg_step      = st;
        cfg_dwell     = dw;
        cfg_mode      = m;
        cfg_valid     = 1'b1;
        tick();
        cfg_valid = 1'b0;
    endtask

    // Expect value v held for n cycles, with the strobe in the first of them.
    task automatic expect_hold(input string tag, input logic [15:0] v, input int n);
        for (int i = 0; i < n; i++) begin
            check({tag, "_phi"}, 32'(phi_inc_o), 32'(v));
            check({tag, "_strobe"}, 32'(step_strobe), 32'(i == 0));
            check({tag, "_busy"}, 32'(sweep_busy), 32'd1);
            check({tag, "_done"}, 32'(sweep_done), 32'd0);
            tick();
        end
    endtask

    task automatic expect_done(input string tag, input logic [15:0] v);
        check({tag, "_done"}, 32'(sweep_done), 32'd1);
        check({tag, "_busy"}, 32'(sweep_busy), 32'd0);
        check({tag, "_ready"}, 32'(cfg_ready), 32'd1);
        check({tag, "_strobe"}, 32'(step_strobe), 32'd0);
        check({tag, "_phi"}, 32'(phi_inc_o), 32'(v));
        tick();
        check({tag, "_done_pulse"}, 32'(sweep_done), 32'd0);
        check({tag, "_phi_hold"}, 32'(phi_inc_o), 32'(v));
    endtask

    task automatic do_abort(input string tag, input logic [15:0] v);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check({tag, "_busy"}, 32'(sweep_busy), 32'd0);
        check({tag, "_ready"}, 32'(cfg_ready), 32'd1);
        check({tag, "_strobe"}, 32'(step_strobe), 32'd0);
        check({tag, "_done"}, 32'(sweep_done), 32'd0);
        check({tag, "_phi"}, 32'(phi_inc_o), 32'(v));
    endtask

    initial begin
        n_vec         = 0;
        n_miss        = 0;
        reset_n       = 1'b0;
        cfg_valid     = 1'b0;
        cfg_start_inc = '0;
        cfg_stop_inc  = '0;
        cfg_step      = '0;
        cfg_dwell     = '0;
        cfg_mode      = '0;
        abort         = 1'b0;

        #1;
        check("rst_phi", 32'(phi_inc_o), 32'd0);
        check("rst_busy", 32'(sweep_busy), 32'd0);
        check("rst_strobe", 32'(step_strobe), 32'd0);
        check("rst_done", 32'(sweep_done), 32'd0);
        check("rst_ready", 32'(cfg_ready), 32'd1);
        #11 reset_n = 1'b1;
        tick();

        // Single sweep, dwell 3: done lands 12 cycles after the accept edge.
        accept(16'd100, 16'd130, 16'd10, 16'd3, 2'b00);
        expect_hold("t1_100", 16'd100, 3);
        expect_hold("t1_110", 16'd110, 3);
        expect_hold("t1_120", 16'd120, 3);
        expect_hold("t1_130", 16'd130, 3);
        expect_done("t1_end", 16'd130);

        // Clamp at stop.
        accept(16'd100, 16'd125, 16'd10, 16'd1, 2'b00);
        expect_hold("t2_100", 16'd100, 1);
        expect_hold("t2_110", 16'd110, 1);
        expect_hold("t2_120", 16'd120, 1);
        expect_hold("t2_125", 16'd125, 1);
        expect_done("t2_end", 16'd125);

        // Carry-out clamps, no wrap.
        accept(16'hFFF0, 16'hFFFF, 16'h0020, 16'd1, 2'b00);
        expect_hold("t2w_fff0", 16'hFFF0, 1);
        expect_hold("t2w_ffff", 16'hFFFF, 1);
        expect_done("t2w_end", 16'hFFFF);

        // Triangle.
        accept(16'd10, 16'd30, 16'd10, 16'd2, 2'b10);
        expect_hold("t3t_10a", 16'd10, 2);
        expect_hold("t3t_20a", 16'd20, 2);
        expect_hold("t3t_30a", 16'd30, 2);
        expect_hold("t3t_20b", 16'd20, 2);
        expect_hold("t3t_10b", 16'd10, 2);
        expect_hold("t3t_20c", 16'd20, 2);
        expect_hold("t3t_30b", 16'd30, 2);
        do_abort("t3t_abort", 16'd20);

        // Repeat.
        accept(16'd10, 16'd30, 16'd10, 16'd2, 2'b01);
        expect_hold("t3r_10a", 16'd10, 2);
        expect_hold("t3r_20a", 16'd20, 2);
        expect_hold("t3r_30a", 16'd30, 2);
        expect_hold("t3r_10b", 16'd10, 2);
        expect_hold("t3r_20b", 16'd20, 2);
        do_abort("t3r_abort", 16'd30);

        // Abort in the 2nd cycle of 110, then an immediate new configuration.
        accept(16'd100, 16'd130, 16'd10, 16'd3, 2'b00);
        expect_hold("t4_100", 16'd100, 3);
        check("t4_110_phi", 32'(phi_inc_o), 32'd110);
        check("t4_110_strobe", 32'(step_strobe), 32'd1);
        tick();
        check("t4_110b_phi", 32'(phi_inc_o), 32'd110);
        do_abort("t4_abort", 16'd110);
        accept(16'd5, 16'd6, 16'd1, 16'd1, 2'b00);
        expect_hold("t4n_5", 16'd5, 1);
        expect_hold("t4n_6", 16'd6, 1);
        expect_done("t4n_end", 16'd6);

        // Degenerate configurations with dwell 0.
        accept(16'd50, 16'd60, 16'd0, 16'd0, 2'b00);
        expect_hold("t5a_50", 16'd50, 1);
        expect_done("t5a_end", 16'd50);
        accept(16'd200, 16'd100, 16'd5, 16'd0, 2'b10);
        expect_hold("t5b_200", 16'd200, 1);
        expect_done("t5b_end", 16'd200);

        // cfg_valid while busy is ignored.
        accept(16'd100, 16'd130, 16'd10, 16'd3, 2'b00);
        cfg_valid     = 1'b1;
        cfg_start_inc = 16'd7;
        check("t5c_ready", 32'(cfg_ready), 32'd0);
        expect_hold("t5c_100", 16'd100, 3);
        expect_hold("t5c_110", 16'd110, 3);
        cfg_valid = 1'b0;
        expect_hold("t5c_120", 16'd120, 3);
        expect_hold("t5c_130", 16'd130, 3);
        expect_done("t5c_end", 16'd130);

        // abort in IDLE has no effect.
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("idle_abort_ready", 32'(cfg_ready), 32'd1);
        check("idle_abort_phi", 32'(phi_inc_o), 32'd130);
        check("idle_abort_strobe", 32'(step_strobe), 32'd0);

        // Handshake wins over abort in the same cycle.
        abort = 1'b1;
        accept(16'd40, 16'd50, 16'd10, 16'd1, 2'b00);
        abort = 1'b0;
        expect_hold("hs_40", 16'd40, 1);
        expect_hold("hs_50", 16'd50, 1);
        expect_done("hs_end", 16'd50);

        // Asynchronous reset mid-sweep.
        accept(16'd100, 16'd130, 16'd10, 16'd3, 2'b00);
        expect_hold("t6_100", 16'd100, 3);
        check("t6_110_phi", 32'(phi_inc_o), 32'd110);
        #3 reset_n = 1'b0;
        #1;
        check("t6_rst_phi", 32'(phi_inc_o), 32'd0);
        check("t6_rst_busy", 32'(sweep_busy), 32'd0);
        check("t6_rst_strobe", 32'(step_strobe), 32'd0);
        check("t6_rst_done", 32'(sweep_done), 32'd0);
        check("t6_rst_ready", 32'(cfg_ready), 32'd1);
        reset_n = 1'b1;
        tick();
        check("t6_post_phi", 32'(phi_inc_o), 32'd0);
        check("t6_post_busy", 32'(sweep_busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
